// File: rtl/gb_host_seq_pkg.sv
// -----------------------------------------------------------------------------
// gb_host_pkg
// Shared definitions for the ghostbus host sequencer: FSM state encoding and
// the legal range of the bus read latency parameter.
// -----------------------------------------------------------------------------
package gb_host_pkg;

    // Sequencer states; IDLE must stay at zero so reset lands in IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } gb_state_e;

    // Supported read latency window (cycles from gb_re to valid gb_din).
    localparam int unsigned RD_LAT_MIN = 32'd1;
    localparam int unsigned RD_LAT_MAX = 32'd15;

    // True when a read latency value is within the supported window.
    function automatic bit rd_lat_legal(input int unsigned lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/gb_host_seq_if.sv
// -----------------------------------------------------------------------------
// gb_host_seq_if
// Bundles the command stream, response stream and ghostbus host-side signals
// of the ghostbus host sequencer.
//   master : the sequencer itself (accepts commands, returns responses,
//            drives the ghostbus address/data/strobes, reads gb_din)
//   slave  : its environment (command front-end, response consumer and the
//            decoded ghostbus tree)
// -----------------------------------------------------------------------------
interface gb_host_seq_if #(
    parameter int unsigned AW = 24,
    parameter int unsigned DW = 32
) ();

    // command stream
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    // response stream
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;

    // ghostbus host side
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_dout;
    logic          gb_we;
    logic          gb_re;
    logic [DW-1:0] gb_din;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  gb_din,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_rdata,
        output gb_addr, gb_dout, gb_we, gb_re
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output gb_din,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_rdata,
        input  gb_addr, gb_dout, gb_we, gb_re
    );

endinterface

// File: rtl/gb_host_seq.sv
// -----------------------------------------------------------------------------
// gb_host_seq
// Upstream host of the ghostbus tree. Accepts one single-word read or write
// command at a time, issues a one-cycle gb_we / gb_re strobe, captures read
// data exactly RD_LAT cycles after gb_re, and returns one response per
// command. Completed transactions are counted in txn_count (wrapping).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        gb_host_seq_if.master: cmd_* stream in, rsp_* stream out,
//              gb_addr/gb_dout/gb_we/gb_re out, gb_din in
//   txn_count  completed-transaction counter
// -----------------------------------------------------------------------------
module gb_host_seq
    import gb_host_pkg::*;
#(
    parameter int unsigned AW     = 24,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned CW     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gb_host_seq_if.master        bus,
    output logic [CW-1:0]        txn_count
);

    localparam int unsigned LW = $clog2(RD_LAT + 1);

    if (!rd_lat_legal(RD_LAT)) begin : g_rd_lat_illegal
        $error("gb_host_seq: RD_LAT must be within 1..15");
    end

    gb_state_e     state_q,     state_d;
    logic [AW-1:0] gb_addr_q,   gb_addr_d;
    logic [DW-1:0] gb_dout_q,   gb_dout_d;
    logic          gb_we_q,     gb_we_d;
    logic          gb_re_q,     gb_re_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_write_q, rsp_write_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [CW-1:0] txn_count_q, txn_count_d;
    logic [LW-1:0] lat_q,       lat_d;

    // Next-state and datapath decode for the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        gb_addr_d   = gb_addr_q;
        gb_dout_d   = gb_dout_q;
        gb_we_d     = 1'b0;          // strobes are single-cycle by construction
        gb_re_d     = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        txn_count_d = txn_count_q;
        lat_d       = lat_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    gb_addr_d = bus.cmd_addr;
                    if (bus.cmd_write) begin
                        // Writes complete immediately: the response is
                        // presented in the same cycle as the gb_we pulse.
                        gb_dout_d   = bus.cmd_wdata;
                        gb_we_d     = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_write_d = 1'b1;
                        rsp_rdata_d = {DW{1'b0}};
                        state_d     = RESP;
                    end else begin
                        // lat_q equals RD_LAT in the gb_re cycle and reaches
                        // zero exactly in the cycle gb_din is valid.
                        gb_re_d = 1'b1;
                        lat_d   = LW'(RD_LAT);
                        state_d = RD_WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            RD_WAIT: begin
                if (lat_q == {LW{1'b0}}) begin
                    rsp_rdata_d = bus.gb_din;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    state_d     = RESP;
                end else begin
                    lat_d = lat_q - LW'(1'b1);
                end
            end

            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    txn_count_d = txn_count_q + CW'(1'b1);
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end

            default: begin
                // Unreachable encoding: recover to IDLE with nothing pending.
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gb_addr_q   <= {AW{1'b0}};
            gb_dout_q   <= {DW{1'b0}};
            gb_we_q     <= 1'b0;
            gb_re_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= {DW{1'b0}};
            txn_count_q <= {CW{1'b0}};
            lat_q       <= {LW{1'b0}};
        end else begin
            state_q     <= state_d;
            gb_addr_q   <= gb_addr_d;
            gb_dout_q   <= gb_dout_d;
            gb_we_q     <= gb_we_d;
            gb_re_q     <= gb_re_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            txn_count_q <= txn_count_d;
            lat_q       <= lat_d;
        end
    end

    // cmd_ready is a pure decode of the registered state, so no path exists
    // from rsp_ready to cmd_ready.
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.gb_addr   = gb_addr_q;
    assign bus.gb_dout   = gb_dout_q;
    assign bus.gb_we     = gb_we_q;
    assign bus.gb_re     = gb_re_q;
    assign txn_count     = txn_count_q;

endmodule

// File: tb/tb_gb_host_seq.sv
// -----------------------------------------------------------------------------
// tb_gb_host_seq
// Directed self-checking bench for gb_host_seq (RD_LAT=2, CW=4). A small bus
// model returns rd_word on gb_din exactly RD_LAT cycles after gb_re and a
// cycle-dependent junk pattern otherwise. A strobe monitor counts gb_we/gb_re
// pulses and flags overlapping or back-to-back strobes.
// -----------------------------------------------------------------------------
module tb_gb_host_seq;

    localparam int unsigned AW     = 24;
    localparam int unsigned DW     = 32;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned CW     = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] txn_count;

    int n_tests  = 0;
    int n_fail   = 0;
    int viol_cnt = 0;
    int we_cnt   = 0;
    int re_cnt   = 0;
    int we0      = 0;
    int re0      = 0;

    logic          prev_strobe = 1'b0;
    logic [1:0]    re_pipe     = 2'b00;
    logic [31:0]   cyc         = 32'd0;
    logic [DW-1:0] rd_word     = 32'd0;

    gb_host_seq_if #(.AW(AW), .DW(DW)) bus_if ();

    gb_host_seq #(
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT),
        .CW     (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    // Bus model: valid data only in the cycle RD_LAT after gb_re.
    always @(posedge clk) begin
        re_pipe <= {re_pipe[0], bus_if.gb_re};
        cyc     <= cyc + 32'd1;
    end
    assign bus_if.gb_din = re_pipe[1] ? rd_word : (32'hBAD0_0000 | cyc);

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus_if.gb_we && bus_if.gb_re) viol_cnt++;
            if ((bus_if.gb_we || bus_if.gb_re) && prev_strobe) viol_cnt++;
            if (bus_if.gb_we) we_cnt++;
            if (bus_if.gb_re) re_cnt++;
            prev_strobe = bus_if.gb_we | bus_if.gb_re;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while ((bus_if.rsp_valid !== 1'b1) && (n < 20)) begin
            step();
            n++;
        end
        chk(tag, {63'd0, bus_if.rsp_valid}, 64'd1);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = 24'h0;
        bus_if.cmd_wdata = 32'h0;
        bus_if.rsp_ready = 1'b0;
        step();
        step();

        // ---- reset values ----
        chk("rst_cmd_ready", {63'd0, bus_if.cmd_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, bus_if.rsp_valid}, 64'd0);
        chk("rst_rsp_write", {63'd0, bus_if.rsp_write}, 64'd0);
        chk("rst_rsp_rdata", {32'd0, bus_if.rsp_rdata}, 64'd0);
        chk("rst_strobes",   {62'd0, bus_if.gb_we, bus_if.gb_re}, 64'd0);
        chk("rst_gb_addr",   {40'd0, bus_if.gb_addr}, 64'd0);
        chk("rst_gb_dout",   {32'd0, bus_if.gb_dout}, 64'd0);
        chk("rst_txn",       {60'd0, txn_count}, 64'd0);
        rst_n = 1'b1;
        step();

        // ---- single write ----
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = 1'b1;
        bus_if.cmd_addr  = 24'h000040;
        bus_if.cmd_wdata = 32'h000000A5;
        bus_if.rsp_ready = 1'b1;
        step();
        chk("wr_we",        {63'd0, bus_if.gb_we}, 64'd1);
        chk("wr_re",        {63'd0, bus_if.gb_re}, 64'd0);
        chk("wr_addr",      {40'd0, bus_if.gb_addr}, 64'h40);
        chk("wr_dout",      {32'd0, bus_if.gb_dout}, 64'hA5);
        chk("wr_rsp_valid", {63'd0, bus_if.rsp_valid}, 64'd1);
        chk("wr_rsp_write", {63'd0, bus_if.rsp_write}, 64'd1);
        chk("wr_rsp_rdata", {32'd0, bus_if.rsp_rdata}, 64'd0);
        chk("wr_cmd_ready", {63'd0, bus_if.cmd_ready}, 64'd0);
        bus_if.cmd_valid = 1'b0;
        step();
        chk("wr_we_drop",   {63'd0, bus_if.gb_we}, 64'd0);
        chk("wr_rsp_done",  {63'd0, bus_if.rsp_valid}, 64'd0);
        chk("wr_ready_ret", {63'd0, bus_if.cmd_ready}, 64'd1);
        chk("wr_txn",       {60'd0, txn_count}, 64'd1);

        // ---- single read, RD_LAT=2 ----
        rd_word          = 32'h00000042;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = 24'h000000;
        bus_if.cmd_wdata = 32'hFFFFFFFF;
        step();                                   // N+1
        chk("rd_re",        {63'd0, bus_if.gb_re}, 64'd1);
        chk("rd_we",        {63'd0, bus_if.gb_we}, 64'd0);
        chk("rd_addr",      {40'd0, bus_if.gb_addr}, 64'h0);
        chk("rd_dout_held", {32'd0, bus_if.gb_dout}, 64'hA5);
        chk("rd_cmd_ready", {63'd0, bus_if.cmd_ready}, 64'd0);
        bus_if.cmd_valid = 1'b0;
        step();                                   // N+2
        chk("rd_re_drop",   {63'd0, bus_if.gb_re}, 64'd0);
        chk("rd_no_rsp_n2", {63'd0, bus_if.rsp_valid}, 64'd0);
        step();                                   // N+3
        chk("rd_no_rsp_n3", {63'd0, bus_if.rsp_valid}, 64'd0);
        step();                                   // N+4
        chk("rd_rsp_valid", {63'd0, bus_if.rsp_valid}, 64'd1);
        chk("rd_rsp_rdata", {32'd0, bus_if.rsp_rdata}, 64'h42);
        chk("rd_rsp_write", {63'd0, bus_if.rsp_write}, 64'd0);
        step();
        chk("rd_rsp_done",  {63'd0, bus_if.rsp_valid}, 64'd0);
        chk("rd_ready_ret", {63'd0, bus_if.cmd_ready}, 64'd1);
        chk("rd_txn",       {60'd0, txn_count}, 64'd2);

        // ---- read with response backpressure ----
        rd_word          = 32'h12345678;
        bus_if.rsp_ready = 1'b0;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = 24'h123456;
        step();
        chk("bp_addr", {40'd0, bus_if.gb_addr}, 64'h123456);
        bus_if.cmd_valid = 1'b0;
        step();
        step();
        step();                                   // first rsp_valid cycle
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", {63'd0, bus_if.rsp_valid}, 64'd1);
            chk("bp_hold_rdata", {32'd0, bus_if.rsp_rdata}, 64'h12345678);
            chk("bp_hold_ready", {63'd0, bus_if.cmd_ready}, 64'd0);
            step();
        end
        chk("bp_hs_rdata", {32'd0, bus_if.rsp_rdata}, 64'h12345678);
        bus_if.rsp_ready = 1'b1;
        step();
        chk("bp_rsp_done",  {63'd0, bus_if.rsp_valid}, 64'd0);
        chk("bp_ready_ret", {63'd0, bus_if.cmd_ready}, 64'd1);
        chk("bp_txn",       {60'd0, txn_count}, 64'd3);

        // ---- back-to-back alternating write/read, cmd_valid held ----
        we0 = we_cnt;
        re0 = re_cnt;
        for (int k = 0; k < 4; k++) begin
            bus_if.cmd_valid = 1'b1;
            bus_if.cmd_write = ((k % 2) == 0);
            bus_if.cmd_addr  = 24'h000100 + k;
            bus_if.cmd_wdata = 32'h5A000000 + k;
            rd_word          = 32'hCAFE0000 + k;
            chk("b2b_cmd_ready", {63'd0, bus_if.cmd_ready}, 64'd1);
            step();
            wait_rsp("b2b_rsp_valid");
            chk("b2b_rsp_write", {63'd0, bus_if.rsp_write}, {63'd0, ((k % 2) == 0)});
            chk("b2b_rsp_rdata", {32'd0, bus_if.rsp_rdata},
                ((k % 2) == 0) ? 64'd0 : {32'd0, 32'hCAFE0000 + k});
            step();
        end
        bus_if.cmd_valid = 1'b0;
        step();
        chk("b2b_txn",      {60'd0, txn_count}, 64'd7);
        chk("b2b_we_count", we_cnt - we0, 64'd2);
        chk("b2b_re_count", re_cnt - re0, 64'd2);

        // ---- reset asserted mid-read while gb_re is high ----
        rd_word          = 32'h00000099;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = 24'h000055;
        step();
        chk("mr_re_before", {63'd0, bus_if.gb_re}, 64'd1);
        bus_if.cmd_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_async_re",    {63'd0, bus_if.gb_re}, 64'd0);
        chk("mr_async_ready", {63'd0, bus_if.cmd_ready}, 64'd1);
        chk("mr_async_addr",  {40'd0, bus_if.gb_addr}, 64'd0);
        chk("mr_async_dout",  {32'd0, bus_if.gb_dout}, 64'd0);
        chk("mr_async_txn",   {60'd0, txn_count}, 64'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("mr_no_rsp",   {63'd0, bus_if.rsp_valid}, 64'd0);
            chk("mr_ready",    {63'd0, bus_if.cmd_ready}, 64'd1);
            step();
        end
        chk("mr_txn", {60'd0, txn_count}, 64'd0);

        // ---- txn_count wrap with CW=4 ----
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = 1'b1;
        bus_if.cmd_addr  = 24'h0000F0;
        bus_if.rsp_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            bus_if.cmd_wdata = 32'(i);
            step();
            step();
            if (i == 15) chk("wrap_15", {60'd0, txn_count}, 64'hF);
            if (i == 16) chk("wrap_16", {60'd0, txn_count}, 64'h0);
            if (i == 17) chk("wrap_17", {60'd0, txn_count}, 64'h1);
        end
        bus_if.cmd_valid = 1'b0;
        step();
        step();

        chk("strobe_rules", viol_cnt, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
